// File: rtl/dmem_arbiter.sv
// Round-robin, lock-capable arbiter sharing one data memory between two requesters.
// Optional grant/conflict statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int D_WIDTH    = 32,
  parameter int LOCK_MAX   = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic               m0_lock,
  input  logic [31:0]        m0_addr,
  input  logic [D_WIDTH-1:0] m0_wdata,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  output logic [D_WIDTH-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic               m1_lock,
  input  logic [31:0]        m1_addr,
  input  logic [D_WIDTH-1:0] m1_wdata,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [D_WIDTH-1:0] m1_rdata,
  output logic               mem_we,
  output logic [31:0]        mem_w_addr,
  output logic [D_WIDTH-1:0] mem_w_data,
  output logic               mem_re,
  output logic [31:0]        mem_r_addr,
  input  logic [D_WIDTH-1:0] mem_r_data
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_gnt0,
  output logic [STAT_WIDTH-1:0] stat_gnt1,
  output logic [STAT_WIDTH-1:0] stat_conflict
`endif
);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  localparam bit         LOCK_EN   = (LOCK_MAX > 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX);

  state_t             state;
  logic               rr_ptr;
  logic [7:0]         lock_cnt;
  logic               rd_pend;
  logic               rd_tag;
  logic [D_WIDTH-1:0] rdata0_q;
  logic [D_WIDTH-1:0] rdata1_q;

  logic               any_gnt;
  logic               sel;
  logic               g_we;
  logic               g_lock;
  logic [31:0]        g_addr;
  logic [D_WIDTH-1:0] g_wdata;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB: begin
          if (m0_req && m1_req) begin
            m0_gnt = !rr_ptr;
            m1_gnt = rr_ptr;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        LOCK0:   m0_gnt = m0_req;
        LOCK1:   m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;
  assign sel     = m1_gnt;
  assign g_we    = sel ? m1_we    : m0_we;
  assign g_lock  = sel ? m1_lock  : m0_lock;
  assign g_addr  = sel ? m1_addr  : m0_addr;
  assign g_wdata = sel ? m1_wdata : m0_wdata;

  assign mem_we     = any_gnt & g_we;
  assign mem_re     = any_gnt & ~g_we;
  assign mem_w_addr = g_addr;
  assign mem_r_addr = g_addr;
  assign mem_w_data = g_wdata;

  // Read data is only valid for one cycle on mem_r_data; the holding registers keep it afterwards.
  assign m0_rvalid = rd_pend & ~rd_tag & ~rst;
  assign m1_rvalid = rd_pend &  rd_tag & ~rst;
  assign m0_rdata  = rst ? '0 : (m0_rvalid ? mem_r_data : rdata0_q);
  assign m1_rdata  = rst ? '0 : (m1_rvalid ? mem_r_data : rdata1_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= 1'b0;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_tag   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rd_pend <= mem_re;
      if (mem_re) rd_tag <= sel;
      if (m0_rvalid) rdata0_q <= mem_r_data;
      if (m1_rvalid) rdata1_q <= mem_r_data;

      if (any_gnt) begin
        if (state == ARB) begin
          rr_ptr <= ~sel;
          if (g_lock && LOCK_EN) begin
            state    <= sel ? LOCK1 : LOCK0;
            lock_cnt <= 8'd1;
          end
        end else if (!g_lock || (lock_cnt + 8'd1) >= LOCK_LAST) begin
          state    <= ARB;
          rr_ptr   <= ~sel;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + 8'd1;
        end
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic conflict;
  assign conflict = (m0_req && m1_req)
                  || (state == LOCK0 && m1_req)
                  || (state == LOCK1 && m0_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (m0_gnt   && stat_gnt0     != '1) stat_gnt0     <= stat_gnt0 + 1'b1;
      if (m1_gnt   && stat_gnt1     != '1) stat_gnt1     <= stat_gnt1 + 1'b1;
      if (conflict && stat_conflict != '1) stat_conflict <= stat_conflict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small write-through memory model behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_w_addr, mem_w_data, mem_r_addr;
  logic [31:0] mem_r_data = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_arr [0:255];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_re(mem_re), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  // Single-port-per-direction memory with one-cycle read latency and write-through.
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_w_addr[9:2]] <= mem_w_data;
    if (mem_re)
      mem_r_data <= (mem_we && mem_w_addr[9:2] == mem_r_addr[9:2]) ? mem_w_data
                                                                    : mem_arr[mem_r_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs settle by the #1.
  task automatic step(input logic r,
                      input logic q0, input logic w0, input logic l0, input logic [31:0] a0,
                      input logic [31:0] d0,
                      input logic q1, input logic w1, input logic l1, input logic [31:0] a1,
                      input logic [31:0] d1);
    @(negedge clk);
    rst = r;
    m0_req = q0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
  endtask

  task automatic chk_g(input string tag, input logic e0, input logic e1);
    check({tag, ".gnt0"}, m0_gnt, e0);
    check({tag, ".gnt1"}, m1_gnt, e1);
  endtask

  task automatic chk_rv(input string tag, input logic e0, input logic e1);
    check({tag, ".rvalid0"}, m0_rvalid, e0);
    check({tag, ".rvalid1"}, m1_rvalid, e1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[8] = 32'h1111_2222;  // 0x20
    mem_arr[9] = 32'h3333_4444;  // 0x24

    // Reset held two cycles with both ports requesting.
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0);
      chk_g("rst", 0, 0);
      chk_rv("rst", 0, 0);
      check("rst.mem_we", mem_we, 0);
      check("rst.mem_re", mem_re, 0);
      check("rst.rdata0", m0_rdata, 0);
    end

    // Continuous contention: grants alternate starting at port 0, data returns a cycle later.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0);
      chk_g($sformatf("alt%0d", i), (i % 2) == 0, (i % 2) == 1);
      check($sformatf("alt%0d.r_addr", i), mem_r_addr, (i % 2) == 0 ? 32'h20 : 32'h24);
      if (i == 0) chk_rv("alt0", 0, 0);
      else chk_rv($sformatf("alt%0d", i), (i % 2) == 1, (i % 2) == 0);
      if (i > 0 && (i % 2) == 1) check($sformatf("alt%0d.rdata0", i), m0_rdata, 32'h1111_2222);
      if (i > 0 && (i % 2) == 0) check($sformatf("alt%0d.rdata1", i), m1_rdata, 32'h3333_4444);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_rv("alt_end", 0, 1);
    check("alt_end.rdata1", m1_rdata, 32'h3333_4444);
    check("alt_end.rdata0_hold", m0_rdata, 32'h1111_2222);
    check("alt_end.mem_re", mem_re, 0);
`ifdef DMEM_ARB_STATS_EN
    check("stat_gnt0", stat_gnt0, 3);
    check("stat_gnt1", stat_gnt1, 3);
    check("stat_conflict", stat_conflict, 6);
`endif

    // Short reset: holding registers and statistics clear.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst2.rdata1", m1_rdata, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst2.rdata0_q", m0_rdata, 0);
`ifdef DMEM_ARB_STATS_EN
    check("rst2.stat_gnt0", stat_gnt0, 0);
    check("rst2.stat_gnt1", stat_gnt1, 0);
    check("rst2.stat_conflict", stat_conflict, 0);
`endif

    // Port 0 write then read of the same word.
    step(0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    chk_g("wr", 1, 0);
    check("wr.mem_we", mem_we, 1);
    check("wr.mem_re", mem_re, 0);
    check("wr.w_addr", mem_w_addr, 32'h10);
    check("wr.w_data", mem_w_data, 32'hDEAD_BEEF);
    step(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    chk_g("rd", 1, 0);
    check("rd.mem_re", mem_re, 1);
    check("rd.mem_we", mem_we, 0);
    check("rd.r_addr", mem_r_addr, 32'h10);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_rv("rd_ret", 1, 0);
    check("rd_ret.rdata0", m0_rdata, 32'hDEAD_BEEF);

    // Port 1 locks for two transfers, then unlocks; port 0 waits throughout (rr_ptr now 1).
    step(0, 1, 0, 0, 32'h20, 0, 1, 0, 1, 32'h24, 0);
    chk_g("lk1a", 0, 1);
    step(0, 1, 0, 0, 32'h20, 0, 1, 0, 1, 32'h24, 0);
    chk_g("lk1b", 0, 1);
    chk_rv("lk1b", 0, 1);
    check("lk1b.rdata1", m1_rdata, 32'h3333_4444);
    step(0, 1, 0, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk1c", 0, 1);
    step(0, 1, 0, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk1d", 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk1e", 0, 1);

    // Port 0 holds lock indefinitely: capped at LOCK_MAX=4 grants, a req gap keeps the lock.
    step(0, 1, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk0a", 1, 0);
    step(0, 1, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk0b", 1, 0);
    step(0, 0, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk0_gap", 0, 0);
    step(0, 1, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk0c", 1, 0);
    step(0, 1, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk0d", 1, 0);
    step(0, 1, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("lk0_cap", 0, 1);

    // Reset while port 1's read is in flight: its rvalid never appears.
    step(1, 1, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("mid_rst", 0, 0);
    chk_rv("mid_rst", 0, 0);
    step(0, 1, 0, 1, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk_g("post_rst", 1, 0);
    chk_rv("post_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-clock data memory between the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1).
- Accepts at most one transfer per cycle and drives the memory's write and read ports.
- Routes each read response back to the requester that issued it.
- Uses round-robin arbitration and supports a bounded lock for atomic read-modify-write sequences.

Parameters:
D_WIDTH, 32, data width; matches the data memory word width
LOCK_MAX, 4, maximum consecutive granted transfers one requester may hold while locked (range 1..255)
STAT_WIDTH, 16, width of the statistics counters (used only with DMEM_ARB_STATS_EN)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
m0_req  input  1  port 0 request valid
m0_we  input  1  port 0: 1 = write, 0 = read
m0_lock  input  1  port 0: keep the grant after this transfer
m0_addr  input  32  port 0 byte address; bits [1:0] ignored
m0_wdata  input  D_WIDTH  port 0 write data
m0_gnt  output  1  port 0 transfer accepted this cycle (combinational)
m0_rvalid  output  1  port 0 read data valid
m0_rdata  output  D_WIDTH  port 0 read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  as port 0, for requester 1
mem_we  output  1  memory write enable
mem_w_addr  output  32  memory write address
mem_w_data  output  D_WIDTH  memory write data
mem_re  output  1  memory read enable
mem_r_addr  output  32  memory read address
mem_r_data  input  D_WIDTH  memory read data, valid the cycle after mem_re

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: the following are 0 at reset and while rst is high:
  - m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_re
  - m0_rdata and m1_rdata
  - rr_ptr = 0 (port 0 has priority first)
  - state = ARB, lock_cnt = 0
- Handshake:
  - A requester holds req, we, lock, addr and wdata stable until it sees gnt=1 at a clock edge.
  - gnt is a combinational function of state, rr_ptr and the req inputs only.
  - At most one gnt is high per cycle; gnt is never high without the matching req.
- Issue:
  - Granted write: mem_we=1, mem_w_addr=addr, mem_w_data=wdata, mem_re=0.
  - Granted read: mem_re=1, mem_r_addr=addr, mem_we=0.
  - When nothing is granted, mem_we=mem_re=0; address and data outputs are don't-care.
- Read return:
  - A read granted in cycle N gives mX_rvalid=1 and mX_rdata=mem_r_data in cycle N+1, for exactly one cycle.
  - A 1-bit tag register records which port issued the read.
  - The other port's rvalid stays 0; its rdata holds its last value.
  - Back-to-back reads, including alternating ports, complete at one per cycle.
- State ARB:
  - Exactly one req: grant it.
  - Both req: grant the port selected by rr_ptr.
  - rr_ptr <= the non-granted port after every grant made in ARB.
  - If the granted transfer has lock=1 and LOCK_MAX>1: go to LOCKn (n = granted port) and set lock_cnt=1.
- State LOCKn:
  - Only port n may be granted; the other port's req is ignored (stalled).
  - A grant with lock=0 ends the sequence: return to ARB, rr_ptr <= other port.
  - A grant with lock=1: lock_cnt increments. When lock_cnt reaches LOCK_MAX, force a return to ARB with rr_ptr <= other port; the lock is not re-entered until the next ARB grant.
  - If port n drops req while in LOCKn, stay in LOCKn; no timeout beyond LOCK_MAX grants.
- Read-after-write: the memory provides write-through when write and read hit the same address in one cycle. The arbiter never issues both in one cycle, so a read granted in the cycle after a write sees the written data.
- Reset mid-operation: a pending rvalid is dropped, a lock is abandoned, and the state returns to ARB. Requesters must reissue.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, three output ports of width STAT_WIDTH are added:
  - stat_gnt0: count of grants to port 0
  - stat_gnt1: count of grants to port 1
  - stat_conflict: count of cycles where both req=1, or where the other port is stalled by a lock
- The counters saturate at all-ones and reset to 0.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with both req=1 -> all gnt/rvalid/mem_we/mem_re = 0; first grant after release goes to port 0.
- Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10 the next cycle -> m0_gnt in both cycles; m0_rvalid=1 with m0_rdata=0xDEADBEEF one cycle after the read grant; m1_rvalid stays 0.
- Both ports request reads continuously (port 0 reads 0x20, port 1 reads 0x24) for 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid alternates one cycle behind, with the correct data on each port.
- Port 1 lock=1 for 2 transfers then lock=0, while port 0 requests throughout -> port 1 gets 3 consecutive grants; port 0 is granted on the 4th cycle.
- LOCK_MAX=4; port 0 holds lock=1 indefinitely and port 1 requests -> port 0 gets 4 grants, then port 1 gets the next grant.
- DMEM_ARB_STATS_EN: run the alternating scenario for 6 cycles -> stat_gnt0=3, stat_gnt1=3, stat_conflict=6; rst clears all three to 0.
